// File: rtl/lsu_n.sv
// lsu_n -- load/store unit sitting directly behind the execute ALU.
//
// Accepts one access at a time from the execute stage. It runs a single
// req/gnt/rvalid data-memory transaction and returns aligned,
// sign/zero-extended load data for writeback. Misaligned or illegal ops
// never reach memory; they produce a one-cycle err_o pulse instead.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     access handshake (ready only while idle)
//   lsu_op_i                      [3] store/load, [2:0] funct3 size/sign
//   alu_data_i                    effective address
//   store_data_i                  rs2 value for stores
//   rd_addr_i                     load destination register
//   dmem_req_o ... dmem_wdata_o   memory request channel (held until gnt)
//   dmem_gnt_i                    request accepted
//   dmem_rvalid_i, dmem_rdata_i   load response
//   done_o                        access completed (load or store)
//   wb_valid_o, wb_data_o, wb_rd_o   load writeback
//   err_o                         misaligned/illegal access rejected
module lsu_n #(
    parameter int n = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [3:0]   lsu_op_i,
    input  logic [n-1:0] alu_data_i,
    input  logic [n-1:0] store_data_i,
    input  logic [4:0]   rd_addr_i,
    output logic         dmem_req_o,
    output logic         dmem_we_o,
    output logic [n-1:0] dmem_addr_o,
    output logic [3:0]   dmem_be_o,
    output logic [n-1:0] dmem_wdata_o,
    input  logic         dmem_gnt_i,
    input  logic         dmem_rvalid_i,
    input  logic [n-1:0] dmem_rdata_i,
    output logic         done_o,
    output logic         wb_valid_o,
    output logic [n-1:0] wb_data_o,
    output logic [4:0]   wb_rd_o,
    output logic         err_o
);

    // Lane logic below is written for exactly four byte lanes.
    if (n != 32) begin : g_width_check
        $error("lsu_n: only n = 32 (four byte lanes) is supported");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    state_e       state_q, state_d;
    logic         store_q, store_d;
    logic [2:0]   funct_q, funct_d;
    logic [n-1:0] addr_q, addr_d;
    logic [n-1:0] sdata_q, sdata_d;
    logic [4:0]   rd_q, rd_d;
    logic [n-1:0] wb_data_q, wb_data_d;
    logic [4:0]   wb_rd_q, wb_rd_d;

    // Reject check on the incoming op. Unsigned sizes exist only for loads,
    // and 011/110/111 are illegal in either direction.
    logic op_bad;
    always_comb begin
        op_bad = 1'b0;
        case (lsu_op_i[2:0])
            3'b000:  op_bad = 1'b0;
            3'b001:  op_bad = alu_data_i[0];
            3'b010:  op_bad = (alu_data_i[1:0] != 2'b00);
            3'b100:  op_bad = lsu_op_i[3];
            3'b101:  op_bad = lsu_op_i[3] | alu_data_i[0];
            default: op_bad = 1'b1;
        endcase
    end

    // Store byte enables and lane-replicated write data. Loads always
    // request the full word with zero write data.
    logic [3:0]   req_be;
    logic [n-1:0] req_wdata;
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = '0;
        if (store_q) begin
            req_wdata = sdata_q;
            case (funct_q[1:0])
                2'b00: begin
                    req_be    = 4'b0001 << addr_q[1:0];
                    req_wdata = {4{sdata_q[7:0]}};
                end
                2'b01: begin
                    req_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{sdata_q[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load lane selection and extension; funct3[2] marks unsigned loads.
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [n-1:0] ld_ext;
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = dmem_rdata_i[7:0];
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct_q[1:0])
            2'b00:   ld_ext = {{(n-8){ld_byte[7] & ~funct_q[2]}}, ld_byte};
            2'b01:   ld_ext = {{(n-16){ld_half[15] & ~funct_q[2]}}, ld_half};
            default: ld_ext = dmem_rdata_i;
        endcase
    end

    // Next-state and output logic. The memory request fields are zero
    // outside REQ so the bus is quiet whenever no request is pending.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct_d      = funct_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        rd_d         = rd_q;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        req_ready_o  = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        done_o       = 1'b0;
        wb_valid_o   = 1'b0;
        err_o        = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    store_d = lsu_op_i[3];
                    funct_d = lsu_op_i[2:0];
                    addr_d  = alu_data_i;
                    sdata_d = store_data_i;
                    rd_d    = rd_addr_i;
                    state_d = op_bad ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = store_q;
                dmem_addr_o  = {addr_q[n-1:2], 2'b00};
                dmem_be_o    = req_be;
                dmem_wdata_o = req_wdata;
                if (dmem_gnt_i) begin
                    state_d = store_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    wb_data_d = ld_ext;
                    wb_rd_d   = rd_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_o     = 1'b1;
                wb_valid_o = ~store_q;
                state_d    = S_IDLE;
            end
            S_ERR: begin
                err_o   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wb_data_o = wb_data_q;
    assign wb_rd_o   = wb_rd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            store_q   <= 1'b0;
            funct_q   <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            funct_q   <= funct_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

endmodule

// File: tb/tb_lsu_n.sv
// tb_lsu_n -- self-checking bench for lsu_n.
// A driver issues accesses and pushes expected memory requests and
// responses into queues. A memory responder answers with configurable
// gnt/rvalid delays, and a monitor pops and compares whenever the DUT
// presents a request or a done/wb/err pulse.
module tb_lsu_n;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  lsu_op_i;
    logic [31:0] alu_data_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_addr_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        done_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        err_o;

    lsu_n #(.n(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .lsu_op_i(lsu_op_i), .alu_data_i(alu_data_i),
        .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .done_o(done_o), .wb_valid_o(wb_valid_o),
        .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;     // 0 store done, 1 load writeback, 2 error
        logic [31:0] data;
        logic [4:0]  rd;
        int          acc_cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          acc_cyc;
    } dreq_t;

    resp_t exp_resp_q[$];
    dreq_t exp_req_q[$];

    // Reference memory, byte granular; the responder keeps its own word store.
    logic [7:0]  ref_mem [int];
    logic [31:0] dev_mem [int];

    int gnt_delay_cfg = 0;
    int rv_delay_cfg  = 0;
    int last_gnt_cyc  = -10;
    int last_rv_cyc   = -10;
    bit stray_rvalid  = 1'b0;
    logic [31:0] last_wb_data = '0;
    logic [4:0]  last_wb_rd   = '0;

    function automatic logic [7:0] init_byte(int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_byte(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] dev_word(int wa);
        if (dev_mem.exists(wa)) return dev_mem[wa];
        return {init_byte(wa + 3), init_byte(wa + 2), init_byte(wa + 1), init_byte(wa)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=progress (cycle %0d)", name, cyc);
    endtask

    task automatic checkResetState();
        checkOutput("rst_ready", {31'd0, req_ready_o}, 32'd1);
        checkOutput("rst_ctrl", {27'd0, dmem_req_o, dmem_we_o, done_o, wb_valid_o, err_o}, 32'd0);
        checkOutput("rst_addr", dmem_addr_o, 32'd0);
        checkOutput("rst_be", {28'd0, dmem_be_o}, 32'd0);
        checkOutput("rst_wdata", dmem_wdata_o, 32'd0);
        checkOutput("rst_wb_data", wb_data_o, 32'd0);
        checkOutput("rst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
    endtask

    // Issue one access (called just after a rising edge) and record what the
    // memory bus and the writeback side are expected to show.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [4:0] rd);
        int    waited;
        int    size;
        bit    uns;
        bit    legal;
        int    a;
        logic [31:0] word;
        logic [31:0] val;
        logic [3:0]  be;
        logic [31:0] wd;
        resp_t r;
        dreq_t q;
        waited = 0;
        while (!req_ready_o) begin
            if (waited >= 200) begin
                failNote("ready_wait");
                req_valid_i = 1'b0;
                return;
            end
            // Junk while busy must be ignored.
            req_valid_i  = 1'($urandom_range(1, 0));
            lsu_op_i     = 4'($urandom);
            alu_data_i   = $urandom;
            store_data_i = $urandom;
            rd_addr_i    = 5'($urandom);
            @(posedge clk_i); #1;
            waited++;
        end
        size  = 1;
        uns   = 1'b0;
        legal = 1'b1;
        case (op[2:0])
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1'b1; legal = !op[3]; end
            3'd5: begin size = 2; uns = 1'b1; legal = !op[3]; end
            default: legal = 1'b0;
        endcase
        if (legal && ((addr % size) != 0)) legal = 1'b0;
        a    = int'(addr);
        word = addr & ~32'd3;
        r.acc_cyc = cyc;
        q.acc_cyc = cyc;
        r.data = '0;
        r.rd   = '0;
        if (!legal) begin
            r.kind = 2;
            exp_resp_q.push_back(r);
        end else if (op[3]) begin
            be = '0;
            wd = '0;
            for (int i = 0; i < 4; i++) begin
                if ((int'(word) + i >= a) && (int'(word) + i < a + size)) be[i] = 1'b1;
                wd[8*i +: 8] = data[8*(i % size) +: 8];
            end
            for (int k = 0; k < size; k++) ref_mem[a + k] = data[8*k +: 8];
            q.we = 1'b1; q.addr = word; q.be = be; q.wdata = wd;
            exp_req_q.push_back(q);
            r.kind = 0;
            exp_resp_q.push_back(r);
        end else begin
            val = '0;
            for (int k = 0; k < size; k++) val[8*k +: 8] = ref_byte(a + k);
            if (!uns && size < 4 && val[8*size - 1]) begin
                for (int k = size; k < 4; k++) val[8*k +: 8] = 8'hFF;
            end
            q.we = 1'b0; q.addr = word; q.be = 4'hF; q.wdata = '0;
            exp_req_q.push_back(q);
            r.kind = 1; r.data = val; r.rd = rd;
            exp_resp_q.push_back(r);
        end
        req_valid_i  = 1'b1;
        lsu_op_i     = op;
        alu_data_i   = addr;
        store_data_i = data;
        rd_addr_i    = rd;
        @(posedge clk_i); #1;
        req_valid_i  = 1'b0;
    endtask

    // Memory responder.
    initial begin
        int gcnt;
        int rcnt;
        bit rd_pending;
        int rd_word;
        logic [31:0] w;
        gcnt = -1; rcnt = 0; rd_pending = 1'b0; rd_word = 0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = $urandom;
            if (!rst_ni) begin
                rd_pending = 1'b0;
                gcnt = -1;
            end else if (stray_rvalid) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = 32'h8000_0080;
                stray_rvalid  = 1'b0;
            end else if (rd_pending) begin
                if (rcnt == 0) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = dev_word(rd_word);
                    rd_pending    = 1'b0;
                    last_rv_cyc   = cyc;
                end else rcnt--;
            end else if (dmem_req_o) begin
                if (gcnt < 0) gcnt = (gnt_delay_cfg < 0) ? int'($urandom_range(3, 0)) : gnt_delay_cfg;
                if (gcnt == 0) begin
                    dmem_gnt_i   = 1'b1;
                    last_gnt_cyc = cyc;
                    gcnt = -1;
                    if (dmem_we_o) begin
                        w = dev_word(int'(dmem_addr_o));
                        for (int i = 0; i < 4; i++)
                            if (dmem_be_o[i]) w[8*i +: 8] = dmem_wdata_o[8*i +: 8];
                        dev_mem[int'(dmem_addr_o)] = w;
                    end else begin
                        rd_pending = 1'b1;
                        rd_word    = int'(dmem_addr_o);
                        rcnt = (rv_delay_cfg < 0) ? int'($urandom_range(3, 0)) : rv_delay_cfg;
                    end
                end else gcnt--;
            end
        end
    end

    // Monitor: request channel, response pulses and writeback hold.
    initial begin
        bit    req_prev;
        bit    have_cur;
        bit    pulse_prev;
        dreq_t cur;
        resp_t r;
        req_prev = 1'b0; have_cur = 1'b0; pulse_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                req_prev = 1'b0; have_cur = 1'b0; pulse_prev = 1'b0;
                last_wb_data = '0; last_wb_rd = '0;
            end else begin
                if (pulse_prev) checkOutput("ready_after_end", {31'd0, req_ready_o}, 32'd1);
                if (dmem_req_o) begin
                    if (last_gnt_cyc == cyc - 1) checkOutput("req_drop_after_gnt", 32'd1, 32'd0);
                    if (!req_prev) begin
                        if (exp_req_q.size() == 0) begin
                            checkOutput("spurious_req", 32'd1, 32'd0);
                            have_cur = 1'b0;
                        end else begin
                            cur = exp_req_q.pop_front();
                            have_cur = 1'b1;
                            checkOutput("req_latency", cyc, cur.acc_cyc + 1);
                        end
                    end
                    if (have_cur) begin
                        checkOutput("req_we", {31'd0, dmem_we_o}, {31'd0, cur.we});
                        checkOutput("req_addr", dmem_addr_o, cur.addr);
                        checkOutput("req_be", {28'd0, dmem_be_o}, {28'd0, cur.be});
                        checkOutput("req_wdata", dmem_wdata_o, cur.wdata);
                    end
                end
                req_prev = dmem_req_o;
                pulse_prev = done_o | err_o | wb_valid_o;
                if (done_o || wb_valid_o || err_o) begin
                    if (exp_resp_q.size() == 0) begin
                        checkOutput("spurious_resp", {29'd0, done_o, wb_valid_o, err_o}, 32'd0);
                    end else begin
                        r = exp_resp_q.pop_front();
                        case (r.kind)
                            0: begin
                                checkOutput("store_flags", {29'd0, done_o, wb_valid_o, err_o}, 32'd4);
                                checkOutput("store_latency", cyc, last_gnt_cyc + 1);
                            end
                            1: begin
                                checkOutput("load_flags", {29'd0, done_o, wb_valid_o, err_o}, 32'd6);
                                checkOutput("load_data", wb_data_o, r.data);
                                checkOutput("load_rd", {27'd0, wb_rd_o}, {27'd0, r.rd});
                                checkOutput("load_latency", cyc, last_rv_cyc + 1);
                                last_wb_data = r.data;
                                last_wb_rd   = r.rd;
                            end
                            default: begin
                                checkOutput("err_flags", {29'd0, done_o, wb_valid_o, err_o}, 32'd1);
                                checkOutput("err_latency", cyc, r.acc_cyc + 1);
                                checkOutput("err_ready", {31'd0, req_ready_o}, 32'd0);
                            end
                        endcase
                    end
                end
                if (!wb_valid_o) begin
                    checkOutput("wb_data_hold", wb_data_o, last_wb_data);
                    checkOutput("wb_rd_hold", {27'd0, wb_rd_o}, {27'd0, last_wb_rd});
                end
            end
        end
    end

    // Main sequence.
    initial begin
        int waited;
        req_valid_i = 1'b0; lsu_op_i = '0; alu_data_i = '0;
        store_data_i = '0; rd_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checkResetState();
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed accesses with zero-wait memory.
        gnt_delay_cfg = 0; rv_delay_cfg = 0;
        applyStimulus(4'b1010, 32'h100, 32'hDEADBEEF, 5'd0);
        applyStimulus(4'b1010, 32'h200, 32'h80FF1234, 5'd0);
        applyStimulus(4'b0000, 32'h203, 32'h0, 5'd3);
        applyStimulus(4'b0100, 32'h203, 32'h0, 5'd4);
        applyStimulus(4'b1010, 32'h200, 32'h80017FFF, 5'd0);
        applyStimulus(4'b0001, 32'h202, 32'h0, 5'd5);
        applyStimulus(4'b1001, 32'h202, 32'h0000ABCD, 5'd0);
        applyStimulus(4'b0010, 32'h101, 32'h0, 5'd6);
        applyStimulus(4'b1001, 32'h001, 32'h1234, 5'd0);
        applyStimulus(4'b1100, 32'h000, 32'h0, 5'd0);

        // Slow memory: request must stay stable until gnt.
        gnt_delay_cfg = 3; rv_delay_cfg = 2;
        applyStimulus(4'b0010, 32'h100, 32'h0, 5'd9);
        applyStimulus(4'b1000, 32'h105, 32'h77, 5'd0);

        // Reset while waiting for rvalid; a later rvalid must be ignored.
        gnt_delay_cfg = 0; rv_delay_cfg = 20;
        applyStimulus(4'b0010, 32'h040, 32'h0, 5'd7);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #2;
        checkResetState();
        exp_resp_q.delete();
        exp_req_q.delete();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        stray_rvalid = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
        rv_delay_cfg = 0;
        applyStimulus(4'b0101, 32'h202, 32'h0, 5'd11);

        // Randomized traffic over a small window so loads hit earlier stores.
        gnt_delay_cfg = -1; rv_delay_cfg = -1;
        for (int i = 0; i < 150; i++) begin
            applyStimulus(4'($urandom), 32'($urandom_range(63, 0)), $urandom, 5'($urandom));
            if ($urandom_range(3, 0) == 0) begin
                @(posedge clk_i); #1;
            end
        end

        waited = 0;
        while ((exp_resp_q.size() != 0 || exp_req_q.size() != 0) && waited < 200) begin
            @(posedge clk_i); #1;
            waited++;
        end
        if (exp_resp_q.size() != 0 || exp_req_q.size() != 0) failNote("drain");
        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
